wb_byte_master: RTL and testbench

Wishbone master bridge driven by a byte-stream command channel, e.g. a UART receiver/transmitter pair. A host writes to and reads from any system slave without firmware on the CPU. Each command is parsed into one 32-bit single Wishbone cycle (sel 4'hF), and a status or data byte sequence is returned. The block attaches as an additional master port on the conbus interconnect, alongside the lm32 instruction and data masters.

---
 rtl/wb_byte_master_if.sv | 34 +++
 rtl/wb_byte_master.sv | 175 +++++++++++++++++
 tb/tb_wb_byte_master.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_byte_master_if.sv
// Byte-stream command channel and Wishbone master signals of wb_byte_master.
// master: the bridge side; slave: the command source/sink and bus slave side.
interface wb_byte_master_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;

  modport master (
    input  rx_data, rx_valid, tx_ready,
    input  wb_dat_i, wb_ack_i,
    output rx_ready, tx_data, tx_valid,
    output wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_we_o, wb_cyc_o, wb_stb_o
  );

  modport slave (
    output rx_data, rx_valid, tx_ready,
    output wb_dat_i, wb_ack_i,
    input  rx_ready, tx_data, tx_valid,
    input  wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_we_o, wb_cyc_o, wb_stb_o
  );
endinterface

// File: rtl/wb_byte_master.sv
// Byte-command to single 32-bit Wishbone cycle bridge ('W'/'R' commands).
// Ports: clk, rst (sync, active-low), wbm (byte channel + Wishbone), busy.
module wb_byte_master #(
  parameter logic [15:0] timeout_cycles = 16'd255
) (
  input  logic              clk,
  input  logic              rst,
  wb_byte_master_if.master  wbm,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    BUS,
    RESP
  } state_t;

  localparam logic [7:0] OP_W  = 8'h57;
  localparam logic [7:0] OP_R  = 8'h52;
  localparam logic [7:0] RSP_K = 8'h4B;
  localparam logic [7:0] RSP_Q = 8'h3F;
  localparam logic [7:0] RSP_T = 8'h54;

  state_t      state;
  logic [1:0]  cnt;
  logic        we;
  logic [15:0] tmo;
  logic [23:0] rd_rest;
  logic [1:0]  left;

  logic rx_fire;
  logic tx_fire;
  logic is_w;
  logic is_r;
  logic tmo_last;

  assign rx_fire  = wbm.rx_valid && wbm.rx_ready;
  assign tx_fire  = wbm.tx_valid && wbm.tx_ready;
  assign is_w     = wbm.rx_data == OP_W;
  assign is_r     = wbm.rx_data == OP_R;
  assign tmo_last = tmo == (timeout_cycles - 16'd1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= 2'd0;
      we           <= 1'b0;
      tmo          <= 16'd0;
      rd_rest      <= 24'd0;
      left         <= 2'd0;
      busy         <= 1'b0;
      wbm.rx_ready <= 1'b1;
      wbm.tx_valid <= 1'b0;
      wbm.tx_data  <= 8'd0;
      wbm.wb_adr_o <= 32'd0;
      wbm.wb_dat_o <= 32'd0;
      wbm.wb_sel_o <= 4'd0;
      wbm.wb_we_o  <= 1'b0;
      wbm.wb_cyc_o <= 1'b0;
      wbm.wb_stb_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rx_fire) begin
            busy <= 1'b1;
            unique case (1'b1)
              is_w, is_r: begin
                we    <= is_w;
                cnt   <= 2'd0;
                state <= ADDR;
              end
              default: begin
                wbm.rx_ready <= 1'b0;
                wbm.tx_valid <= 1'b1;
                wbm.tx_data  <= RSP_Q;
                left         <= 2'd0;
                state        <= RESP;
              end
            endcase
          end
        end

        ADDR: begin
          if (rx_fire) begin
            wbm.wb_adr_o <= {wbm.wb_adr_o[23:0], wbm.rx_data};
            cnt          <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              if (we) begin
                state <= DATA;
              end else begin
                wbm.rx_ready <= 1'b0;
                wbm.wb_cyc_o <= 1'b1;
                wbm.wb_stb_o <= 1'b1;
                wbm.wb_we_o  <= 1'b0;
                wbm.wb_sel_o <= 4'hF;
                tmo          <= 16'd0;
                state        <= BUS;
              end
            end
          end
        end

        DATA: begin
          if (rx_fire) begin
            wbm.wb_dat_o <= {wbm.wb_dat_o[23:0], wbm.rx_data};
            cnt          <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              wbm.rx_ready <= 1'b0;
              wbm.wb_cyc_o <= 1'b1;
              wbm.wb_stb_o <= 1'b1;
              wbm.wb_we_o  <= 1'b1;
              wbm.wb_sel_o <= 4'hF;
              tmo          <= 16'd0;
              state        <= BUS;
            end
          end
        end

        BUS: begin
          // Ack is checked first so a same-cycle ack beats the abort.
          if (wbm.wb_ack_i) begin
            wbm.wb_cyc_o <= 1'b0;
            wbm.wb_stb_o <= 1'b0;
            wbm.wb_we_o  <= 1'b0;
            wbm.wb_sel_o <= 4'd0;
            wbm.tx_valid <= 1'b1;
            state        <= RESP;
            if (we) begin
              wbm.tx_data <= RSP_K;
              left        <= 2'd0;
            end else begin
              wbm.tx_data <= wbm.wb_dat_i[31:24];
              rd_rest     <= wbm.wb_dat_i[23:0];
              left        <= 2'd3;
            end
          end else if (tmo_last) begin
            wbm.wb_cyc_o <= 1'b0;
            wbm.wb_stb_o <= 1'b0;
            wbm.wb_we_o  <= 1'b0;
            wbm.wb_sel_o <= 4'd0;
            wbm.tx_valid <= 1'b1;
            wbm.tx_data  <= RSP_T;
            left         <= 2'd0;
            state        <= RESP;
          end else begin
            tmo <= tmo + 16'd1;
          end
        end

        RESP: begin
          if (tx_fire) begin
            if (left == 2'd0) begin
              wbm.tx_valid <= 1'b0;
              wbm.rx_ready <= 1'b1;
              busy         <= 1'b0;
              state        <= IDLE;
            end else begin
              // Remaining read bytes leave MSB first.
              wbm.tx_data <= rd_rest[23:16];
              rd_rest     <= {rd_rest[15:0], 8'h00};
              left        <= left - 2'd1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_byte_master.sv
// Directed bench for wb_byte_master: write, read, bad opcode, timeout,
// backpressure and reset recovery against a small Wishbone slave model.
module tb_wb_byte_master;
  logic clk = 1'b0;
  logic rst;
  logic busy;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  logic        ack_on;
  int          ack_at;
  logic [31:0] rdata;

  int          stb_run   = 0;
  int          stb_total = 0;
  int          rx_acc    = 0;
  int          bad       = 0;
  logic [31:0] cap_adr;
  logic [31:0] cap_dat;
  logic        cap_we;
  logic [3:0]  cap_sel;

  wb_byte_master_if bus_if ();

  wb_byte_master #(
    .timeout_cycles(16'd8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .wbm  (bus_if),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Slave: acks on the ack_at-th stb cycle when ack_on is set.
  always @(posedge clk) begin
    #1;
    if (bus_if.wb_stb_o === 1'b1) begin
      stb_run   = stb_run + 1;
      stb_total = stb_total + 1;
      cap_adr   = bus_if.wb_adr_o;
      cap_dat   = bus_if.wb_dat_o;
      cap_we    = bus_if.wb_we_o;
      cap_sel   = bus_if.wb_sel_o;
    end else begin
      stb_run = 0;
    end
    bus_if.wb_ack_i = (bus_if.wb_stb_o === 1'b1) && ack_on
                      && (stb_run == ack_at);
    bus_if.wb_dat_i = rdata;
  end

  always @(negedge clk) begin
    if (bus_if.rx_valid && bus_if.rx_ready)
      rx_acc = rx_acc + 1;
    if ((bus_if.wb_cyc_o || bus_if.tx_valid) && bus_if.rx_ready)
      bad = bad + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    int   n;
    bus_if.rx_data  = b;
    bus_if.rx_valid = 1'b1;
    n = 0;
    do begin
      acc = bus_if.rx_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    bus_if.rx_valid = 1'b0;
    chk("rx_accept", {31'd0, acc}, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--)
      send_byte(w[i*8 +: 8]);
  endtask

  task automatic get_resp(input int want, input bit toggle,
                          output logic [31:0] word, output int got);
    logic       tr;
    logic       fire;
    logic [7:0] d;
    int         cyc;
    word = 32'd0;
    got  = 0;
    tr   = 1'b1;
    cyc  = 0;
    while (got < want && cyc < 60) begin
      bus_if.tx_ready = tr;
      fire = bus_if.tx_valid && tr;
      d    = bus_if.tx_data;
      @(posedge clk);
      #1;
      cyc++;
      if (fire) begin
        word = {word[23:0], d};
        got++;
      end
      if (toggle) tr = ~tr;
    end
    bus_if.tx_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    int n;
    int s0;
    int a0;
    int b0;

    rst             = 1'b0;
    bus_if.rx_valid = 1'b0;
    bus_if.rx_data  = 8'h00;
    bus_if.tx_ready = 1'b0;
    ack_on          = 1'b1;
    ack_at          = 1;
    rdata           = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_ready", {31'd0, bus_if.rx_ready}, 32'd1);
    chk("rst_tx_valid", {31'd0, bus_if.tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, bus_if.tx_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cyc_stb", {30'd0, bus_if.wb_cyc_o, bus_if.wb_stb_o}, 32'd0);
    chk("rst_we_sel", {27'd0, bus_if.wb_we_o, bus_if.wb_sel_o}, 32'd0);
    chk("rst_adr", bus_if.wb_adr_o, 32'd0);
    chk("rst_dat", bus_if.wb_dat_o, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Write, slave acks on the 3rd stb cycle.
    ack_at = 3;
    s0 = stb_total;
    send_byte(8'h57);
    send_word(32'h4000_0000);
    send_word(32'h0000_00A5);
    chk("wr_cyc_rise", {31'd0, bus_if.wb_cyc_o}, 32'd1);
    chk("wr_stb_rise", {31'd0, bus_if.wb_stb_o}, 32'd1);
    chk("wr_busy", {31'd0, busy}, 32'd1);
    chk("wr_rx_ready_bus", {31'd0, bus_if.rx_ready}, 32'd0);
    get_resp(1, 1'b0, w, n);
    chk("wr_resp_cnt", n, 32'd1);
    chk("wr_resp", w, 32'h0000_004B);
    chk("wr_stb_cycles", stb_total - s0, 32'd3);
    chk("wr_adr", cap_adr, 32'h4000_0000);
    chk("wr_dat", cap_dat, 32'h0000_00A5);
    chk("wr_we", {31'd0, cap_we}, 32'd1);
    chk("wr_sel", {28'd0, cap_sel}, 32'hF);

    // Read, zero-wait slave.
    ack_at = 1;
    rdata  = 32'hDEAD_BEEF;
    s0 = stb_total;
    send_byte(8'h52);
    send_word(32'h3000_0004);
    get_resp(4, 1'b0, w, n);
    chk("rd_resp_cnt", n, 32'd4);
    chk("rd_resp", w, 32'hDEAD_BEEF);
    chk("rd_we", {31'd0, cap_we}, 32'd0);
    chk("rd_adr", cap_adr, 32'h3000_0004);
    chk("rd_stb_cycles", stb_total - s0, 32'd1);

    // Unknown opcode, then a read right after.
    s0 = stb_total;
    send_byte(8'h41);
    get_resp(1, 1'b0, w, n);
    chk("unk_resp", w, 32'h0000_003F);
    chk("unk_no_cycle", stb_total - s0, 32'd0);
    chk("unk_rx_ready", {31'd0, bus_if.rx_ready}, 32'd1);
    rdata = 32'h1234_5678;
    send_byte(8'h52);
    send_word(32'h0000_0010);
    get_resp(4, 1'b0, w, n);
    chk("unk_next_rd", w, 32'h1234_5678);
    chk("unk_next_adr", cap_adr, 32'h0000_0010);

    // Timeout with ack tied low.
    ack_on = 1'b0;
    s0 = stb_total;
    send_byte(8'h52);
    send_word(32'h0000_0100);
    get_resp(1, 1'b0, w, n);
    chk("tmo_resp", w, 32'h0000_0054);
    chk("tmo_stb_cycles", stb_total - s0, 32'd8);
    repeat (3) @(posedge clk);
    #1;
    chk("tmo_no_extra", {31'd0, bus_if.tx_valid}, 32'd0);
    chk("tmo_idle", {31'd0, busy}, 32'd0);

    // Ack on the final timeout cycle wins.
    ack_on = 1'b1;
    ack_at = 8;
    rdata  = 32'hCAFE_F00D;
    s0 = stb_total;
    send_byte(8'h52);
    send_word(32'h0000_0104);
    get_resp(4, 1'b0, w, n);
    chk("tmo_ack8_cnt", n, 32'd4);
    chk("tmo_ack8_resp", w, 32'hCAFE_F00D);
    chk("tmo_ack8_stb", stb_total - s0, 32'd8);

    // Backpressure: tx_ready toggles, next command byte held on rx.
    ack_at = 2;
    rdata  = 32'hA1B2_C3D4;
    b0 = bad;
    send_byte(8'h52);
    send_word(32'h0000_0200);
    bus_if.rx_data  = 8'h52;
    bus_if.rx_valid = 1'b1;
    a0 = rx_acc;
    get_resp(4, 1'b1, w, n);
    chk("bp_resp_cnt", n, 32'd4);
    chk("bp_resp", w, 32'hA1B2_C3D4);
    chk("bp_rx_held", rx_acc - a0, 32'd0);
    chk("bp_rx_ready_low", bad - b0, 32'd0);
    chk("bp_b2b_ready", {31'd0, bus_if.rx_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus_if.rx_valid = 1'b0;
    chk("bp_held_taken", {31'd0, busy}, 32'd1);
    ack_at = 1;
    rdata  = 32'h0BAD_F00D;
    send_word(32'h0000_0300);
    get_resp(4, 1'b0, w, n);
    chk("bp_next_rd", w, 32'h0BAD_F00D);
    chk("bp_next_adr", cap_adr, 32'h0000_0300);

    // Reset during the 3rd address byte.
    send_byte(8'h57);
    send_byte(8'h10);
    send_byte(8'h00);
    bus_if.rx_data  = 8'h00;
    bus_if.rx_valid = 1'b1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rsta_cyc_stb", {30'd0, bus_if.wb_cyc_o, bus_if.wb_stb_o}, 32'd0);
    chk("rsta_tx_valid", {31'd0, bus_if.tx_valid}, 32'd0);
    chk("rsta_busy", {31'd0, busy}, 32'd0);
    chk("rsta_adr", bus_if.wb_adr_o, 32'd0);
    rst = 1'b1;
    bus_if.rx_valid = 1'b0;

    // Reset during BUS.
    ack_on = 1'b0;
    send_byte(8'h52);
    send_word(32'h0000_0400);
    chk("rstb_in_bus", {31'd0, bus_if.wb_cyc_o}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rstb_cyc_stb", {30'd0, bus_if.wb_cyc_o, bus_if.wb_stb_o}, 32'd0);
    chk("rstb_tx_valid", {31'd0, bus_if.tx_valid}, 32'd0);
    chk("rstb_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("rstb_no_resp", {31'd0, bus_if.tx_valid}, 32'd0);

    // Full write after reset, zero-wait slave, cycle-exact latency.
    ack_on = 1'b1;
    ack_at = 1;
    bus_if.tx_ready = 1'b1;
    s0 = stb_total;
    send_byte(8'h57);
    send_word(32'h5000_0008);
    send_word(32'h1122_3344);
    chk("lat_t1_cyc", {31'd0, bus_if.wb_cyc_o}, 32'd1);
    @(posedge clk);
    #1;
    chk("lat_t2_cyc", {31'd0, bus_if.wb_cyc_o}, 32'd0);
    chk("lat_t2_tx", {23'd0, bus_if.tx_valid, bus_if.tx_data}, 32'h14B);
    @(posedge clk);
    #1;
    chk("lat_t3_tx", {31'd0, bus_if.tx_valid}, 32'd0);
    chk("lat_t3_idle", {30'd0, busy, bus_if.rx_ready}, 32'd1);
    chk("lat_adr", cap_adr, 32'h5000_0008);
    chk("lat_dat", cap_dat, 32'h1122_3344);
    chk("lat_stb", stb_total - s0, 32'd1);
    bus_if.tx_ready = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
